// File: rtl/dsm_dac_pkg.sv
// Shared types and helpers for the multi-channel delta-sigma DAC.
// Provides the modulator order enum, integrator width offset and saturation.
package dsm_dac_pkg;

    typedef enum logic {
        ORD1 = 1'b0,
        ORD2 = 1'b1
    } order_e;

    // Integrators carry this many bits above the sample width.
    localparam int INT_OFS = 4;

    // Clamp v to +/-(2^(dw+2)-1), the integrator limit for sample width dw.
    function automatic logic signed [31:0] sat(
        input logic signed [31:0] v,
        input int                 dw
    );
        logic signed [31:0] lim;
        lim = (32'sd1 <<< (dw + INT_OFS - 2)) - 32'sd1;
        if (v > lim) return lim;
        if (v < -lim) return -lim;
        return v;
    endfunction

endpackage

// File: rtl/dsm_mod_ch.sv
// Single-channel 1st/2nd-order delta-sigma modulator with 1-bit output.
// Ports: clk, rst (sync, active high), en_ch (channel enable),
//        order2 (1 = 2nd order), clr_int (clear integrators),
//        x (signed input sample), dac_bit (registered modulator output).
module dsm_mod_ch
    import dsm_dac_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en_ch,
    input  logic                     order2,
    input  logic                     clr_int,
    input  logic signed [DATA_W-1:0] x,
    output logic                     dac_bit
);

    localparam int IW = DATA_W + INT_OFS;
    localparam logic signed [31:0] HALF = 32'sd1 <<< (DATA_W - 1);

    logic signed [IW-1:0] i1;
    logic signed [IW-1:0] i2;
    logic signed [31:0]   fb;
    logic signed [31:0]   i1_nx;
    logic signed [31:0]   i2_nx;

    // Sums are formed at 32 bits so they cannot wrap before clamping.
    always_comb begin
        fb    = dac_bit ? HALF : -HALF;
        i1_nx = sat(32'(i1) + 32'(x) - fb, DATA_W);
        i2_nx = sat(32'(i2) + i1_nx - fb, DATA_W);
    end

    always_ff @(posedge clk) begin
        if (rst || !en_ch || clr_int) begin
            i1      <= '0;
            i2      <= '0;
            dac_bit <= 1'b0;
        end else begin
            i1 <= i1_nx[IW-1:0];
            if (order2) begin
                i2      <= i2_nx[IW-1:0];
                dac_bit <= (i2_nx >= 32'sd0);
            end else begin
                i2      <= '0;
                dac_bit <= (i1_nx >= 32'sd0);
            end
        end
    end

endmodule

// File: rtl/dsm_dac_multich.sv
// Multi-channel delta-sigma DAC: shared sample port, frame timer, per-channel
// pending/active sample registers, sticky underrun flags and modulators.
// Ports: clk, rst, en (timer run), ch_en, order2, s_valid/s_ready/s_ch/s_data
//        (sample write), frame_tick (sample request), dac_out, underrun,
//        clr_status (clear underrun flags).
module dsm_dac_multich
    import dsm_dac_pkg::*;
#(
    parameter  int NUM_CH = 2,
    parameter  int DATA_W = 16,
    parameter  int OSR    = 64,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [NUM_CH-1:0]        ch_en,
    input  logic                     order2,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [CH_W-1:0]          s_ch,
    input  logic signed [DATA_W-1:0] s_data,
    output logic                     frame_tick,
    output logic [NUM_CH-1:0]        dac_out,
    output logic [NUM_CH-1:0]        underrun,
    input  logic                     clr_status
);

    localparam int CNT_W = $clog2(OSR);

    logic [CNT_W-1:0] cnt;
    logic             tick;
    logic             wr;
    logic             ord_chg;
    order_e           ord;

    assign tick       = en && (cnt == CNT_W'(OSR - 1));
    assign frame_tick = tick;
    assign wr         = s_valid && s_ready;
    assign ord_chg    = tick && (order_e'(order2) != ord);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            s_ready <= 1'b0;
            ord     <= ORD1;
        end else begin
            s_ready <= 1'b1;
            if (en) cnt <= tick ? '0 : cnt + 1'b1;
            if (ord_chg) ord <= order_e'(order2);
        end
    end

    // Channel indices with no channel behind them match no byp, so such
    // writes are accepted and dropped.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic                     byp;
        logic                     fresh_q;
        logic                     ur_q;
        logic signed [DATA_W-1:0] pend_q;
        logic signed [DATA_W-1:0] act_q;

        assign byp         = wr && (int'(s_ch) == c);
        assign underrun[c] = ur_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                fresh_q <= 1'b0;
                ur_q    <= 1'b0;
                pend_q  <= '0;
                act_q   <= '0;
            end else begin
                if (byp) pend_q <= s_data;
                if (tick) begin
                    // A write landing on the tick bypasses pending.
                    if (byp) act_q <= s_data;
                    else if (fresh_q) act_q <= pend_q;
                    fresh_q <= 1'b0;
                end else if (byp) begin
                    fresh_q <= 1'b1;
                end
                if (tick && !byp && !fresh_q) ur_q <= 1'b1;
                else if (clr_status) ur_q <= 1'b0;
            end
        end

        dsm_mod_ch #(
            .DATA_W (DATA_W)
        ) u_mod (
            .clk     (clk),
            .rst     (rst),
            .en_ch   (ch_en[c]),
            .order2  (ord == ORD2),
            .clr_int (ord_chg),
            .x       (act_q),
            .dac_bit (dac_out[c])
        );
    end

endmodule

// File: tb/tb_dsm_dac_multich.sv
// Self-checking bench for dsm_dac_multich.
// Three channels are used so that channel index 3 is genuinely out of range.
module tb_dsm_dac_multich;

    localparam int NCH = 3;
    localparam int DW  = 16;
    localparam int OSR = 64;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 en = 1'b0;
    logic                 order2 = 1'b0;
    logic                 s_valid = 1'b0;
    logic                 clr_status = 1'b0;
    logic [NCH-1:0]       ch_en = '0;
    logic [1:0]           s_ch = '0;
    logic signed [DW-1:0] s_data = '0;
    logic                 s_ready;
    logic                 frame_tick;
    logic [NCH-1:0]       dac_out;
    logic [NCH-1:0]       underrun;

    always #5 clk = ~clk;

    dsm_dac_multich #(
        .NUM_CH (NCH),
        .DATA_W (DW),
        .OSR    (OSR)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .ch_en      (ch_en),
        .order2     (order2),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_ch       (s_ch),
        .s_data     (s_data),
        .frame_tick (frame_tick),
        .dac_out    (dac_out),
        .underrun   (underrun),
        .clr_status (clr_status)
    );

    typedef struct {
        int    ch;
        int    lo;
        int    hi;
        string tag;
    } win_t;

    win_t sb[$];
    int   total = 0;
    int   bad = 0;

    // Bench-side model of timer, handshake and underrun flags.
    int             cnt_m = 0;
    int             frame_m = 0;
    logic           rdy_m = 1'b0;
    logic [NCH-1:0] fresh_m = '0;
    logic [NCH-1:0] ur_m = '0;
    logic [NCH-1:0] live_m = '0;

    logic                 chk_on = 1'b0;
    logic                 man_wr = 1'b0;
    logic                 skip1 = 1'b0;
    logic                 ft_seen = 1'b0;
    logic [NCH-1:0]       feed = '0;
    logic signed [DW-1:0] feed_x [NCH];
    int                   ones [NCH];

    task automatic expect_win(input int ch, input int lo, input int hi,
                              input string tag);
        win_t w;
        w.ch  = ch;
        w.lo  = lo;
        w.hi  = hi;
        w.tag = tag;
        sb.push_back(w);
    endtask

    // One clock: drive feeder, check tick, update model, check outputs.
    task automatic step();
        logic tk;
        logic wr;
        logic byp;
        #1;
        if (!man_wr) begin
            s_valid = 1'b0;
            if (!rst && cnt_m < NCH && feed[cnt_m]
                && !(skip1 && cnt_m == 1 && (frame_m % 2) == 1)) begin
                s_valid = 1'b1;
                s_ch    = 2'(cnt_m);
                s_data  = feed_x[cnt_m];
            end
        end
        tk      = en && (cnt_m == OSR - 1);
        ft_seen = frame_tick;
        if (chk_on) begin
            total++;
            if (frame_tick !== tk) begin
                bad++;
                $display("FAIL tick: got %b want %b t=%0t",
                         frame_tick, tk, $time);
            end
        end
        wr = s_valid && rdy_m;
        if (rst) begin
            cnt_m   = 0;
            rdy_m   = 1'b0;
            fresh_m = '0;
            ur_m    = '0;
            live_m  = '0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                byp = wr && (int'(s_ch) == c);
                if (tk) begin
                    if (!byp && !fresh_m[c]) ur_m[c] = 1'b1;
                    else if (clr_status) ur_m[c] = 1'b0;
                    fresh_m[c] = 1'b0;
                end else begin
                    if (clr_status) ur_m[c] = 1'b0;
                    if (byp) fresh_m[c] = 1'b1;
                end
            end
            rdy_m  = 1'b1;
            live_m = ch_en;
            if (en) cnt_m = tk ? 0 : cnt_m + 1;
            if (tk) frame_m++;
        end
        @(posedge clk);
        #1;
        if (chk_on) begin
            total++;
            if (s_ready !== rdy_m) begin
                bad++;
                $display("FAIL s_ready: got %b want %b t=%0t",
                         s_ready, rdy_m, $time);
            end
            total++;
            if (underrun !== ur_m) begin
                bad++;
                $display("FAIL underrun: got %b want %b t=%0t",
                         underrun, ur_m, $time);
            end
            total++;
            if ((dac_out & ~live_m) !== '0) begin
                bad++;
                $display("FAIL dac_off: got %b live %b t=%0t",
                         dac_out, live_m, $time);
            end
        end
        for (int c = 0; c < NCH; c++) ones[c] += int'(dac_out[c]);
        @(negedge clk);
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic wait_cnt(input int target);
        for (int i = 0; i < 2 * OSR; i++) begin
            if (cnt_m == target) break;
            step();
        end
    endtask

    task automatic measure(input int len);
        win_t w;
        w = sb.pop_front();
        ones[w.ch] = 0;
        run(len);
        total++;
        if (ones[w.ch] < w.lo || ones[w.ch] > w.hi) begin
            bad++;
            $display("FAIL %s: ones=%0d want %0d..%0d",
                     w.tag, ones[w.ch], w.lo, w.hi);
        end
    endtask

    task automatic tick_gap(input string tag);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!ft_seen && n < 200);
        total++;
        if (n != OSR) begin
            bad++;
            $display("FAIL %s: gap=%0d want %0d", tag, n, OSR);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en  = 1'b0;
        step();
        chk_on = 1'b1;
        run(2);
        total++;
        if (dac_out !== '0 || underrun !== '0) begin
            bad++;
            $display("FAIL rst_out: dac=%b ur=%b want 0", dac_out, underrun);
        end
        total++;
        if (s_ready !== 1'b0 || frame_tick !== 1'b0) begin
            bad++;
            $display("FAIL rst_hs: rdy=%b tick=%b want 0",
                     s_ready, frame_tick);
        end
        rst = 1'b0;
        step();
        total++;
        if (s_ready !== 1'b1) begin
            bad++;
            $display("FAIL rdy_up: got %b want 1", s_ready);
        end
    endtask

    task automatic test_zero_input();
        ch_en     = 3'b001;
        order2    = 1'b0;
        feed      = 3'b001;
        feed_x[0] = '0;
        en        = 1'b1;
        tick_gap("first_tick_wait");
        tick_gap("tick_period");
        run(2 * OSR);
        expect_win(0, 32, 32, "x_zero");
        measure(OSR);
    endtask

    task automatic test_levels();
        int xs [4] = '{16384, -32768, 32767, 0};
        int lo [4] = '{47, 0, 63, 32};
        int hi [4] = '{49, 0, 64, 32};
        for (int i = 0; i < 4; i++) begin
            feed_x[0] = 16'(xs[i]);
            run(3 * OSR);
            expect_win(0, lo[i], hi[i], $sformatf("lvl_%0d", xs[i]));
            measure(OSR);
        end
    endtask

    task automatic test_second_order();
        order2    = 1'b1;
        feed_x[0] = -16'sd8192;
        run(4 * OSR);
        expect_win(0, 95, 97, "ord2_m8192");
        measure(4 * OSR);
        order2 = 1'b0;
        run(2 * OSR);
    endtask

    task automatic test_underrun();
        logic found;
        ch_en     = 3'b011;
        feed      = 3'b011;
        feed_x[0] = '0;
        feed_x[1] = '0;
        skip1     = 1'b0;
        run(OSR);
        clr_status = 1'b1;
        step();
        clr_status = 1'b0;
        run(2 * OSR);
        total++;
        if (underrun[1:0] !== 2'b00) begin
            bad++;
            $display("FAIL ur_fed: got %b want 00", underrun[1:0]);
        end
        skip1 = 1'b1;
        run(3 * OSR);
        total++;
        if (underrun[1:0] !== 2'b10) begin
            bad++;
            $display("FAIL ur_skip: got %b want 10", underrun[1:0]);
        end
        found = 1'b0;
        for (int i = 0; i < 4 * OSR; i++) begin
            if (cnt_m == OSR - 1 && !fresh_m[1]) begin
                found = 1'b1;
                break;
            end
            step();
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL miss_wait: timeout got 0 want 1");
        end
        clr_status = 1'b1;
        step();
        clr_status = 1'b0;
        total++;
        if (underrun[1] !== 1'b1) begin
            bad++;
            $display("FAIL set_wins: got %b want 1", underrun[1]);
        end
        wait_cnt(20);
        clr_status = 1'b1;
        step();
        clr_status = 1'b0;
        total++;
        if (underrun[1:0] !== 2'b00) begin
            bad++;
            $display("FAIL clr: got %b want 00", underrun[1:0]);
        end
        skip1 = 1'b0;
    endtask

    task automatic test_bypass();
        feed  = '0;
        ch_en = 3'b001;
        wait_cnt(10);
        clr_status = 1'b1;
        step();
        clr_status = 1'b0;
        man_wr  = 1'b1;
        s_valid = 1'b1;
        s_ch    = 2'd0;
        s_data  = -16'sd32768;
        step();
        s_valid = 1'b0;
        wait_cnt(OSR - 1);
        s_valid = 1'b1;
        s_data  = 16'sd32767;
        step();
        s_valid = 1'b0;
        total++;
        if (underrun[0] !== 1'b0) begin
            bad++;
            $display("FAIL byp_ur: got %b want 0", underrun[0]);
        end
        run(16);
        expect_win(0, 63, 64, "bypass_new");
        measure(OSR);
        wait_cnt(10);
        s_valid = 1'b1;
        s_ch    = 2'd3;
        s_data  = -16'sd32768;
        step();
        s_valid = 1'b0;
        run(OSR);
        total++;
        if (underrun[0] !== 1'b1) begin
            bad++;
            $display("FAIL ch3_drop: ur0 got %b want 1", underrun[0]);
        end
        expect_win(0, 63, 64, "ch3_ignored");
        measure(OSR);
        man_wr = 1'b0;
    endtask

    task automatic test_reset_mid();
        ch_en     = 3'b011;
        feed      = 3'b011;
        feed_x[0] = 16'sd16384;
        feed_x[1] = -16'sd8192;
        en        = 1'b1;
        run(2 * OSR);
        wait_cnt(30);
        rst = 1'b1;
        step();
        total++;
        if (dac_out !== '0 || underrun !== '0 || s_ready !== 1'b0) begin
            bad++;
            $display("FAIL mid_rst: dac=%b ur=%b rdy=%b want 0",
                     dac_out, underrun, s_ready);
        end
        rst = 1'b0;
        en  = 1'b0;
        run(5);
        en = 1'b1;
        tick_gap("post_rst_tick");
        ch_en   = 3'b001;
        ones[1] = 0;
        run(2 * OSR);
        total++;
        if (ones[1] !== 0) begin
            bad++;
            $display("FAIL ch1_off: ones=%0d want 0", ones[1]);
        end
    endtask

    initial begin
        for (int c = 0; c < NCH; c++) begin
            feed_x[c] = '0;
            ones[c]   = 0;
        end
        @(negedge clk);
        test_reset();
        test_zero_input();
        test_levels();
        test_second_order();
        test_underrun();
        test_bypass();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
